// File: rtl/data_mem_sequencer.sv
// Load/store sequencer between the memory stage and a req/ack word memory.
// Checks legality, lane-aligns stores, and extends load data on completion.
module data_mem_sequencer #(
    parameter int N       = 32,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [6:0]   opcode,
    input  logic [2:0]   funct3,
    input  logic [N-1:0] addr,
    input  logic [N-1:0] wdata,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] rdata,
    output logic         err,
    output logic [1:0]   err_code,
    output logic         mem_req,
    output logic         mem_we,
    output logic [N-1:0] mem_addr,
    output logic [3:0]   mem_be,
    output logic [N-1:0] mem_wdata,
    input  logic         mem_ack,
    input  logic [N-1:0] mem_rdata
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam int         CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg;
    logic [CW-1:0]   cnt_inc;
    logic [2:0]      funct3_reg;
    logic [1:0]      off_reg;
    logic [N-1:0]    rdata_reg;
    logic            err_reg;
    logic [1:0]      err_code_reg;
    logic            mem_we_reg;
    logic [N-1:0]    mem_addr_reg;
    logic [3:0]      mem_be_reg;
    logic [N-1:0]    mem_wdata_reg;

    logic            is_load, is_store, f3_legal, misaligned, accept, timeout_hit;
    logic [3:0]      be_calc;
    logic [N-1:0]    wdata_calc;
    logic [7:0]      rd_byte [4];
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [N-1:0]    load_ext;

    // Request decode: funct3[1:0] is the access size for both loads and stores.
    always_comb begin
        is_load    = (opcode == OP_LOAD);
        is_store   = (opcode == OP_STORE);
        f3_legal   = 1'b0;
        misaligned = 1'b0;
        be_calc    = 4'b1111;
        wdata_calc = '0;
        if (is_load)
            f3_legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
        else if (is_store)
            f3_legal = (funct3[2] == 1'b0) && (funct3[1:0] != 2'b11);
        case (funct3[1:0])
            2'b01:   misaligned = addr[0];
            2'b10:   misaligned = (addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
        if (is_store) begin
            case (funct3[1:0])
                2'b00: begin
                    be_calc    = 4'b0001 << addr[1:0];
                    wdata_calc = {4{wdata[7:0]}};
                end
                2'b01: begin
                    be_calc    = 4'b0011 << addr[1:0];
                    wdata_calc = {2{wdata[15:0]}};
                end
                default: begin
                    be_calc    = 4'b1111;
                    wdata_calc = wdata;
                end
            endcase
        end
        accept = start && (is_load || is_store);
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign rd_byte[gi] = mem_rdata[8*gi +: 8];
        end
    endgenerate

    // funct3[2] set means the unsigned load variant.
    always_comb begin
        byte_sel = rd_byte[off_reg];
        half_sel = off_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_reg[1:0])
            2'b00:   load_ext = {{(N-8){~funct3_reg[2] & byte_sel[7]}}, byte_sel};
            2'b01:   load_ext = {{(N-16){~funct3_reg[2] & half_sel[15]}}, half_sel};
            default: load_ext = mem_rdata;
        endcase
    end

    assign cnt_inc     = cnt_reg + CW'(1);
    assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == CW'(TIMEOUT));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept && f3_legal && !misaligned) state_next = REQ;
            REQ: begin
                if (mem_ack)          state_next = RESP;
                else if (timeout_hit) state_next = IDLE;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg       <= '0;
            funct3_reg    <= '0;
            off_reg       <= '0;
            rdata_reg     <= '0;
            err_reg       <= 1'b0;
            err_code_reg  <= '0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_be_reg    <= '0;
            mem_wdata_reg <= '0;
        end else begin
            err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        funct3_reg    <= funct3;
                        off_reg       <= addr[1:0];
                        mem_we_reg    <= is_store;
                        mem_addr_reg  <= {addr[N-1:2], 2'b00};
                        mem_be_reg    <= be_calc;
                        mem_wdata_reg <= wdata_calc;
                        cnt_reg       <= '0;
                        // Illegal funct3 outranks misalignment.
                        if (!f3_legal) begin
                            err_reg      <= 1'b1;
                            err_code_reg <= 2'b10;
                        end else if (misaligned) begin
                            err_reg      <= 1'b1;
                            err_code_reg <= 2'b01;
                        end
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        if (!mem_we_reg) rdata_reg <= load_ext;
                    end else if (timeout_hit) begin
                        err_reg      <= 1'b1;
                        err_code_reg <= 2'b11;
                    end else begin
                        cnt_reg <= cnt_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == RESP);
    assign mem_req   = (state_reg == REQ);
    assign rdata     = rdata_reg;
    assign err       = err_reg;
    assign err_code  = err_code_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_be    = mem_be_reg;
    assign mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_data_mem_sequencer.sv
// Directed bench for data_mem_sequencer: vector table plus hand-written
// sequences for timeout, busy-ignore, stray ack and mid-operation reset.
module tb_data_mem_sequencer;

    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        busy, done, err, mem_req, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [1:0]  err_code;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    int n_total = 0;
    int n_bad = 0;
    logic [31:0] exp_rdata = '0;

    data_mem_sequencer #(.N(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .funct3(funct3),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
        .err(err), .err_code(err_code), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mrd;
        int          dly;
        logic        exp_err;
        logic [1:0]  exp_code;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl [15];

    function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] mrd, input int dly,
                                input logic e, input logic [1:0] code,
                                input logic [3:0] be, input logic [31:0] ewd,
                                input logic [31:0] erd);
        vec_t v;
        v.op = op; v.f3 = f3; v.addr = a; v.wdata = wd; v.mrd = mrd; v.dly = dly;
        v.exp_err = e; v.exp_code = code; v.exp_be = be; v.exp_wd = ewd; v.exp_rd = erd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input vec_t v, input int id);
        logic [31:0] ea;
        ea = {v.addr[31:2], 2'b00};
        start = 1'b1; opcode = v.op; funct3 = v.f3; addr = v.addr; wdata = v.wdata;
        tick();
        start = 1'b0;
        if (v.exp_err) begin
            chk($sformatf("v%0d_err", id), {31'b0, err}, 32'd1);
            chk($sformatf("v%0d_code", id), {30'b0, err_code}, {30'b0, v.exp_code});
            chk($sformatf("v%0d_noreq", id), {31'b0, mem_req}, 32'd0);
            chk($sformatf("v%0d_rdata_kept", id), rdata, v.exp_rd);
            tick();
            chk($sformatf("v%0d_err_pulse", id), {31'b0, err}, 32'd0);
        end else begin
            chk($sformatf("v%0d_req", id), {31'b0, mem_req}, 32'd1);
            chk($sformatf("v%0d_busy", id), {31'b0, busy}, 32'd1);
            chk($sformatf("v%0d_addr", id), mem_addr, ea);
            chk($sformatf("v%0d_be", id), {28'b0, mem_be}, {28'b0, v.exp_be});
            chk($sformatf("v%0d_we", id), {31'b0, mem_we}, {31'b0, v.op == ST});
            if (v.op == ST) chk($sformatf("v%0d_wdata", id), mem_wdata, v.exp_wd);
            for (int k = 0; k < v.dly; k++) begin
                tick();
                chk($sformatf("v%0d_hold%0d", id, k),
                    {mem_addr[31:4], mem_be, 2'b0, done, mem_req},
                    {ea[31:4], v.exp_be, 2'b0, 1'b0, 1'b1});
                if (v.op == ST) chk($sformatf("v%0d_wd_hold%0d", id, k), mem_wdata, v.exp_wd);
            end
            mem_ack = 1'b1; mem_rdata = v.mrd;
            tick();
            mem_ack = 1'b0; mem_rdata = 32'h5A5A5A5A;
            chk($sformatf("v%0d_done", id), {31'b0, done}, 32'd1);
            chk($sformatf("v%0d_rdata", id), rdata, v.exp_rd);
            chk($sformatf("v%0d_req_off", id), {30'b0, mem_req, busy}, 32'd1);
            tick();
            chk($sformatf("v%0d_after", id), {29'b0, done, busy, err}, 32'd0);
        end
        exp_rdata = v.exp_rd;
        $display("op %0d: opcode=%b f3=%b addr=%h rdata=%h err=%b code=%b",
                 id, v.op, v.f3, v.addr, rdata, err, err_code);
    endtask

    initial begin
        int cnt;
        tbl[0]  = mk(LD, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, 0, 0, 4'hF, 0, 32'hDEADBEEF);
        tbl[1]  = mk(LD, 3'b000, 32'h103, 0, 32'h80112233, 0, 0, 0, 4'hF, 0, 32'hFFFFFF80);
        tbl[2]  = mk(LD, 3'b100, 32'h103, 0, 32'h80112233, 0, 0, 0, 4'hF, 0, 32'h00000080);
        tbl[3]  = mk(ST, 3'b001, 32'h206, 32'h0000ABCD, 0, 3, 0, 0, 4'hC, 32'hABCDABCD, 32'h00000080);
        tbl[4]  = mk(LD, 3'b010, 32'h102, 0, 0, 0, 1, 2'b01, 4'hF, 0, 32'h00000080);
        tbl[5]  = mk(LD, 3'b011, 32'h100, 0, 0, 0, 1, 2'b10, 4'hF, 0, 32'h00000080);
        tbl[6]  = mk(ST, 3'b000, 32'h201, 32'h12345677, 0, 1, 0, 0, 4'h2, 32'h77777777, 32'h00000080);
        tbl[7]  = mk(LD, 3'b001, 32'h102, 0, 32'h80011234, 2, 0, 0, 4'hF, 0, 32'hFFFF8001);
        tbl[8]  = mk(LD, 3'b101, 32'h100, 0, 32'h12349ABC, 0, 0, 0, 4'hF, 0, 32'h00009ABC);
        tbl[9]  = mk(ST, 3'b110, 32'h001, 0, 0, 0, 1, 2'b10, 4'hF, 0, 32'h00009ABC);
        tbl[10] = mk(LD, 3'b001, 32'h101, 0, 0, 0, 1, 2'b01, 4'hF, 0, 32'h00009ABC);
        tbl[11] = mk(ST, 3'b010, 32'h040, 32'hCAFEF00D, 0, 1, 0, 0, 4'hF, 32'hCAFEF00D, 32'h00009ABC);
        tbl[12] = mk(LD, 3'b000, 32'h101, 0, 32'h00007F00, 0, 0, 0, 4'hF, 0, 32'h0000007F);
        tbl[13] = mk(ST, 3'b011, 32'h100, 0, 0, 0, 1, 2'b10, 4'hF, 0, 32'h0000007F);
        tbl[14] = mk(ST, 3'b001, 32'h2FD, 32'h00001234, 0, 0, 1, 2'b01, 4'hF, 0, 32'h0000007F);

        #12;
        chk("reset_ctrl", {26'b0, busy, done, err, err_code, mem_req}, 32'd0);
        chk("reset_we_be", {27'b0, mem_we, mem_be}, 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        chk("reset_addr", mem_addr, 32'd0);
        chk("reset_wdata", mem_wdata, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 15; i++) run_op(tbl[i], i);

        // Unrelated opcode is ignored; an ack outside REQ does nothing.
        start = 1'b1; opcode = 7'b0110011; funct3 = 3'b010; addr = 32'h100;
        tick();
        start = 1'b0;
        chk("ign_op", {29'b0, busy, err, mem_req}, 32'd0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("stray_ack", {29'b0, busy, done, mem_req}, 32'd0);
        tick();
        chk("stray_ack2", {30'b0, done, err}, 32'd0);
        $display("ignored opcode / stray ack: busy=%b done=%b err=%b", busy, done, err);

        // Start while busy is neither taken nor queued.
        start = 1'b1; opcode = LD; funct3 = 3'b010; addr = 32'h500;
        tick();
        addr = 32'h600;
        tick();
        start = 1'b0;
        chk("busy_ign_addr", mem_addr, 32'h500);
        mem_ack = 1'b1; mem_rdata = 32'h11223344;
        tick();
        mem_ack = 1'b0;
        chk("busy_ign_done", {31'b0, done}, 32'd1);
        chk("busy_ign_rdata", rdata, 32'h11223344);
        tick();
        tick();
        chk("busy_ign_noq", {30'b0, busy, mem_req}, 32'd0);
        exp_rdata = 32'h11223344;
        $display("busy ignore: rdata=%h busy=%b", rdata, busy);

        // Timeout with TIMEOUT=4.
        start = 1'b1; opcode = ST; funct3 = 3'b010; addr = 32'h010; wdata = 32'h1;
        tick();
        start = 1'b0;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (!mem_req) break;
            if (done) chk("to_no_done", {31'b0, done}, 32'd0);
            cnt++;
            tick();
        end
        chk("to_req_cycles", cnt, 32'd4);
        chk("to_err", {31'b0, err}, 32'd1);
        chk("to_code", {30'b0, err_code}, 32'd3);
        chk("to_busy", {30'b0, busy, done}, 32'd0);
        chk("to_rdata", rdata, exp_rdata);
        tick();
        chk("to_err_pulse", {31'b0, err}, 32'd0);
        $display("timeout: req_cycles=%0d err_code=%b", cnt, err_code);

        // Reset during REQ drops mem_req immediately.
        start = 1'b1; opcode = LD; funct3 = 3'b010; addr = 32'h700;
        tick();
        start = 1'b0;
        chk("rst_pre_req", {31'b0, mem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_req_drop", {30'b0, mem_req, busy}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        tick();
        rst_n = 1'b1;
        chk("rst_no_evt", {30'b0, done, err}, 32'd0);
        tick();
        chk("rst_idle", {29'b0, done, err, busy}, 32'd0);
        $display("mid-op reset: mem_req=%b busy=%b", mem_req, busy);
        run_op(mk(LD, 3'b101, 32'h302, 0, 32'h98765432, 0, 0, 0, 4'hF, 0, 32'h00009876), 99);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/data_mem_sequencer.md
Name: data_mem_sequencer

Overview:
- Sequences one load or store at a time between the core's memory stage and a word-wide data memory that uses a request/acknowledge handshake.
- Checks alignment and funct3 legality, and aligns store data into byte lanes with byte enables.
- Holds the request until acknowledged or until a timeout expires.
- Extracts and sign- or zero-extends load data, and reports busy so the pipeline can stall.

Parameters:
N, 32, data and address bus width (lanes fixed at 4 bytes; N must be 32)
TIMEOUT, 16, maximum cycles in REQ waiting for mem_ack; 0 disables the timeout

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  pulse/level: accept operation when IDLE
opcode  input  7  RISC-V opcode; LOAD=0000011, STORE=0100011
funct3  input  3  width/sign selector
addr  input  N  byte address
wdata  input  N  store data, right-justified
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse on successful completion
rdata  output  N  extended load result; valid with done, held until next done
err  output  1  one-cycle pulse on aborted operation
err_code  output  2  01 misaligned, 10 illegal funct3, 11 timeout; held until next err
mem_req  output  1  memory request
mem_we  output  1  1 = write
mem_addr  output  N  {addr[N-1:2], 2'b00}
mem_be  output  4  byte enables
mem_wdata  output  N  lane-aligned store data
mem_ack  input  1  memory accepted/completed the request this cycle
mem_rdata  input  N  read word; valid in the mem_ack cycle

Behaviour:
- Reset, asynchronous and active-low: state=IDLE, timeout counter=0. All outputs are 0: busy, done, err, err_code, rdata, mem_req, mem_we, mem_addr, mem_be, mem_wdata.
- States are IDLE, REQ and RESP.
- IDLE, start=1, opcode LOAD or STORE: register opcode class, funct3, addr[1:0], mem_addr, mem_be, mem_wdata and mem_we.
  - Legal access: go to REQ; mem_req=1 from the next cycle.
  - Illegal or misaligned access: stay in IDLE; err=1 and err_code are set the next cycle; no mem_req.
- IDLE, start=1, any other opcode: ignored; no done and no err.
- Legality:
  - Loads accept funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores accept funct3 000 SB, 001 SH, 010 SW.
  - Any other funct3 gives err_code 10.
  - Misaligned means half with addr[0]=1, or word with addr[1:0]!=0; gives err_code 01.
  - If funct3 is illegal, code 10 takes priority over misalignment.
- Store lanes, with off = addr[1:0]:
  - byte: be = 0001<<off, wdata[7:0] replicated to all four lanes.
  - half: be = 0011<<off, wdata[15:0] replicated to both halves.
  - word: be = 1111, wdata unchanged.
- Loads drive mem_be=1111 and mem_we=0.
- REQ:
  - mem_req and all mem_* outputs are held stable until mem_ack.
  - mem_ack=1: for a load, capture mem_rdata; then go to RESP. An ack in the first REQ cycle is legal.
  - Timeout counter increments each REQ cycle without ack. When TIMEOUT>0 and the count reaches TIMEOUT: mem_req drops, go to IDLE, err=1 with err_code 11 the next cycle, rdata unchanged.
- RESP, lasting one cycle: done=1 and mem_req=0.
  - For a load, rdata = selected lane extended: LB/LBU use byte[off], LH/LHU use half[off[1]], LW uses the word.
  - Sign extension for LB/LH, zero extension for LBU/LHU.
  - For a store, rdata keeps its previous value.
  - Next state IDLE; busy=1 in this cycle.
- Latency for a legal access with ack in the first REQ cycle: start at cycle 0, mem_req at cycle 1, ack at cycle 1, done at cycle 2; a new start is accepted at cycle 3.
- start while busy is ignored and not queued.
- mem_ack outside REQ is ignored.
- rst_n asserted mid-operation: mem_req drops immediately (asynchronously); no done or err is generated.
- The timeout counter is cleared on entry to REQ.

Test Plan:
1. LW addr=0x100, mem_rdata=0xDEADBEEF, ack in first REQ cycle -> mem_be=1111, mem_addr=0x100, done at cycle 2, rdata=0xDEADBEEF.
2. LB addr=0x103 and LBU addr=0x103, mem_rdata=0x80112233 -> LB rdata=0xFFFFFF80; LBU rdata=0x00000080; mem_addr=0x100.
3. SH addr=0x206, wdata=0x0000ABCD, ack after 3 cycles -> mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD, all mem_* stable for 3 cycles, done once.
4. LW addr=0x102 -> err=1 with err_code=01 next cycle, no mem_req. Load with funct3=011 -> err_code=10.
5. TIMEOUT=4, SW with no ack -> mem_req high for exactly 4 cycles, then err_code=11, busy=0, no done.
6. rst_n low during REQ -> mem_req=0 at once; after release, LHU addr=0x302 with mem_rdata=0x9876xxxx completes with rdata=0x00009876.
